// File: rtl/clint_axi_pkg.sv
// Shared types and constants for the CLINT AXI initiator.
package clint_axi_pkg;

    // Initiator FSM states
    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWrResp,
        StRead,
        StRdData,
        StResp
    } state_e;

    // AXI response codes
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Fixed burst attributes: one 8-byte INCR beat
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // CLINT register offsets from the slave base
    localparam logic [15:0] CLINT_MSIP_OFFSET     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFFSET = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFFSET    = 16'hBFF8;

    // Anything but OKAY is reported as an error, EXOKAY included, since
    // this master never issues exclusive accesses.
    function automatic logic resp_is_err(logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

    // All CLINT registers are accessed as 64-bit words
    function automatic logic addr_is_aligned(logic [2:0] addr_lo);
        return addr_lo == 3'b000;
    endfunction

endpackage

// File: rtl/clint_axi_initiator.sv
// Single-outstanding AXI4 master turning a valid/ready command into one
// single-beat read or write on the CLINT slave port.
module clint_axi_initiator
    import clint_axi_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        aclk,
    input  logic                        areset,

    // Command channel
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [63:0]                 cmd_wdata,
    input  logic [7:0]                  cmd_wstrb,

    // Response channel
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [63:0]                 rsp_rdata,
    output logic                        rsp_err,

    // AXI write address
    output logic [AXI_ID_WIDTH-1:0]     m_axi_clint_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_clint_awaddr,
    output logic [7:0]                  m_axi_clint_awlen,
    output logic [2:0]                  m_axi_clint_awsize,
    output logic [1:0]                  m_axi_clint_awburst,
    output logic [2:0]                  m_axi_clint_awprot,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_clint_awuser,
    output logic                        m_axi_clint_awvalid,
    input  logic                        m_axi_clint_awready,

    // AXI write data
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_clint_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_clint_wstrb,
    output logic                        m_axi_clint_wlast,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_clint_wuser,
    output logic                        m_axi_clint_wvalid,
    input  logic                        m_axi_clint_wready,

    // AXI write response
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_clint_bid,
    input  logic [1:0]                  m_axi_clint_bresp,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi_clint_buser,
    input  logic                        m_axi_clint_bvalid,
    output logic                        m_axi_clint_bready,

    // AXI read address
    output logic [AXI_ID_WIDTH-1:0]     m_axi_clint_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_clint_araddr,
    output logic [7:0]                  m_axi_clint_arlen,
    output logic [2:0]                  m_axi_clint_arsize,
    output logic [1:0]                  m_axi_clint_arburst,
    output logic [2:0]                  m_axi_clint_arprot,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_clint_aruser,
    output logic                        m_axi_clint_arvalid,
    input  logic                        m_axi_clint_arready,

    // AXI read data
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_clint_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_clint_rdata,
    input  logic [1:0]                  m_axi_clint_rresp,
    input  logic                        m_axi_clint_rlast,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi_clint_ruser,
    input  logic                        m_axi_clint_rvalid,
    output logic                        m_axi_clint_rready
);

    localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ID_WIDTH-1:0] AxiIdVal = AXI_ID_WIDTH'(AXI_ID);

    state_e state_q;

    // Write handshakes still outstanding at the end of this cycle
    logic aw_left;
    logic w_left;

    // User sideband on the response channels carries nothing we act on
    logic unused_user;

    assign unused_user = ^{m_axi_clint_buser, m_axi_clint_ruser};

    // Burst attributes never change: one 8-byte INCR beat with a fixed ID
    assign m_axi_clint_awid    = AxiIdVal;
    assign m_axi_clint_awlen   = AXI_LEN_SINGLE;
    assign m_axi_clint_awsize  = AXI_SIZE_8B;
    assign m_axi_clint_awburst = AXI_BURST_INCR;
    assign m_axi_clint_awprot  = 3'b000;
    assign m_axi_clint_awuser  = '0;
    assign m_axi_clint_wuser   = '0;
    assign m_axi_clint_arid    = AxiIdVal;
    assign m_axi_clint_arlen   = AXI_LEN_SINGLE;
    assign m_axi_clint_arsize  = AXI_SIZE_8B;
    assign m_axi_clint_arburst = AXI_BURST_INCR;
    assign m_axi_clint_arprot  = 3'b000;
    assign m_axi_clint_aruser  = '0;

    // AW and W retire independently; a channel is finished once its valid
    // is low or it handshakes this cycle.
    always_comb begin
        aw_left = m_axi_clint_awvalid && !m_axi_clint_awready;
        w_left  = m_axi_clint_wvalid && !m_axi_clint_wready;
    end

    // Transaction FSM with every handshake and response output registered
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q             <= StIdle;
            cmd_ready           <= 1'b1;
            rsp_valid           <= 1'b0;
            rsp_rdata           <= '0;
            rsp_err             <= 1'b0;
            m_axi_clint_awaddr  <= '0;
            m_axi_clint_awvalid <= 1'b0;
            m_axi_clint_wdata   <= '0;
            m_axi_clint_wstrb   <= '0;
            m_axi_clint_wlast   <= 1'b0;
            m_axi_clint_wvalid  <= 1'b0;
            m_axi_clint_bready  <= 1'b0;
            m_axi_clint_araddr  <= '0;
            m_axi_clint_arvalid <= 1'b0;
            m_axi_clint_rready  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready          <= 1'b0;
                        // Payload is latched here and left untouched until the
                        // next command, which keeps it stable under valid.
                        m_axi_clint_awaddr <= cmd_addr;
                        m_axi_clint_araddr <= cmd_addr;
                        m_axi_clint_wdata  <= AXI_DATA_WIDTH'(cmd_wdata);
                        m_axi_clint_wstrb  <= StrbWidth'(cmd_wstrb);
                        rsp_rdata          <= '0;
                        rsp_err            <= 1'b0;
                        if (!addr_is_aligned(cmd_addr[2:0])) begin
                            // Misaligned: answer locally, no bus traffic
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            state_q   <= StResp;
                        end else if (cmd_write) begin
                            m_axi_clint_awvalid <= 1'b1;
                            m_axi_clint_wvalid  <= 1'b1;
                            m_axi_clint_wlast   <= 1'b1;
                            state_q             <= StWrite;
                        end else begin
                            m_axi_clint_arvalid <= 1'b1;
                            state_q             <= StRead;
                        end
                    end
                end

                StWrite: begin
                    if (!aw_left) begin
                        m_axi_clint_awvalid <= 1'b0;
                    end
                    if (!w_left) begin
                        m_axi_clint_wvalid <= 1'b0;
                        m_axi_clint_wlast  <= 1'b0;
                    end
                    if (!aw_left && !w_left) begin
                        m_axi_clint_bready <= 1'b1;
                        state_q            <= StWrResp;
                    end
                end

                StWrResp: begin
                    if (m_axi_clint_bvalid) begin
                        m_axi_clint_bready <= 1'b0;
                        rsp_err   <= resp_is_err(m_axi_clint_bresp) ||
                                     (m_axi_clint_bid != AxiIdVal);
                        rsp_valid <= 1'b1;
                        state_q   <= StResp;
                    end
                end

                StRead: begin
                    if (m_axi_clint_arready) begin
                        m_axi_clint_arvalid <= 1'b0;
                        m_axi_clint_rready  <= 1'b1;
                        state_q             <= StRdData;
                    end
                end

                StRdData: begin
                    if (m_axi_clint_rvalid) begin
                        m_axi_clint_rready <= 1'b0;
                        rsp_rdata <= 64'(m_axi_clint_rdata);
                        // A single-beat read must come back with RLAST set
                        rsp_err   <= resp_is_err(m_axi_clint_rresp) ||
                                     (m_axi_clint_rid != AxiIdVal) ||
                                     !m_axi_clint_rlast;
                        rsp_valid <= 1'b1;
                        state_q   <= StResp;
                    end
                end

                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end

                default: begin
                    state_q   <= StIdle;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_axi_initiator.sv
// Directed bench for clint_axi_initiator against a small CLINT slave model
// with per-channel ready/valid delays.
module tb_clint_axi_initiator;

    localparam logic [63:0] BASE       = 64'h0000_0000_0200_0000;
    localparam logic [63:0] MTIME_VAL  = 64'h0000_0012_3456_789A;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [63:0] cmd_addr = '0, cmd_wdata = '0;
    logic [7:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [63:0] rsp_rdata;

    logic [9:0]  awid, arid;
    logic [63:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst;
    logic [0:0]  awuser, wuser, aruser;
    logic        awvalid, wvalid, arvalid, wlast, bready, rready;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [9:0]  bid = '0, rid = '0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [0:0]  buser = '0, ruser = '0;
    logic        bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [63:0] rdata = '0;

    int total = 0;
    int bad   = 0;

    // Slave configuration
    int         aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [9:0] bid_cfg = '0, rid_cfg = '0;
    logic       rlast_cfg = 1'b1;

    // Slave state and observations
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    int          aw_hi, w_hi, ar_hi, aw_hi_last, w_hi_last, ar_hi_last;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic        aw_got, w_got, b_pend, r_pend, b_armed, r_armed;
    logic        aw_prev_v, ar_prev_v, w_prev_v;
    logic [63:0] aw_prev_a, ar_prev_a, w_prev_d;
    int          stab_err = 0;
    logic        any_valid = 1'b0;
    logic [63:0] aw_addr_cap, ar_addr_cap, wdata_cap;
    logic [7:0]  wstrb_cap;

    // CLINT register model
    logic [31:0] msip = '0;
    logic [63:0] mtimecmp = '0;
    logic        ipi;
    assign ipi = msip[0];

    clint_axi_initiator #(
        .AXI_ID_WIDTH   (10),
        .AXI_ADDR_WIDTH (64),
        .AXI_DATA_WIDTH (64),
        .AXI_USER_WIDTH (1),
        .AXI_ID         (0)
    ) dut (
        .aclk                (aclk),
        .areset              (areset),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_write           (cmd_write),
        .cmd_addr            (cmd_addr),
        .cmd_wdata           (cmd_wdata),
        .cmd_wstrb           (cmd_wstrb),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_rdata           (rsp_rdata),
        .rsp_err             (rsp_err),
        .m_axi_clint_awid    (awid),
        .m_axi_clint_awaddr  (awaddr),
        .m_axi_clint_awlen   (awlen),
        .m_axi_clint_awsize  (awsize),
        .m_axi_clint_awburst (awburst),
        .m_axi_clint_awprot  (awprot),
        .m_axi_clint_awuser  (awuser),
        .m_axi_clint_awvalid (awvalid),
        .m_axi_clint_awready (awready),
        .m_axi_clint_wdata   (wdata),
        .m_axi_clint_wstrb   (wstrb),
        .m_axi_clint_wlast   (wlast),
        .m_axi_clint_wuser   (wuser),
        .m_axi_clint_wvalid  (wvalid),
        .m_axi_clint_wready  (wready),
        .m_axi_clint_bid     (bid),
        .m_axi_clint_bresp   (bresp),
        .m_axi_clint_buser   (buser),
        .m_axi_clint_bvalid  (bvalid),
        .m_axi_clint_bready  (bready),
        .m_axi_clint_arid    (arid),
        .m_axi_clint_araddr  (araddr),
        .m_axi_clint_arlen   (arlen),
        .m_axi_clint_arsize  (arsize),
        .m_axi_clint_arburst (arburst),
        .m_axi_clint_arprot  (arprot),
        .m_axi_clint_aruser  (aruser),
        .m_axi_clint_arvalid (arvalid),
        .m_axi_clint_arready (arready),
        .m_axi_clint_rid     (rid),
        .m_axi_clint_rdata   (rdata),
        .m_axi_clint_rresp   (rresp),
        .m_axi_clint_rlast   (rlast),
        .m_axi_clint_ruser   (ruser),
        .m_axi_clint_rvalid  (rvalid),
        .m_axi_clint_rready  (rready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] apply_strb(logic [63:0] old, logic [63:0] d, logic [7:0] s);
        logic [63:0] r = old;
        for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_read(logic [63:0] a);
        logic [63:0] off = a - BASE;
        case (off[15:0])
            16'h0000: return {32'h0, msip};
            16'h4000: return mtimecmp;
            16'hBFF8: return MTIME_VAL;
            default:  return 64'h0;
        endcase
    endfunction

    // Slave model: drives on the falling edge, DUT samples on the rising edge
    always @(negedge aclk) begin
        if (areset) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
            aw_hi = 0; w_hi = 0; ar_hi = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_armed = 0; r_armed = 0;
            aw_prev_v = 0; ar_prev_v = 0; w_prev_v = 0;
        end else begin
            // B channel
            if (bvalid && b_armed) begin bvalid = 0; b_cnt++; end
            if (b_pend && !bvalid) begin
                if (b_wait == b_delay) begin
                    logic [63:0] off;
                    bvalid = 1; bid = bid_cfg; bresp = bresp_cfg; b_pend = 0;
                    off = aw_addr_cap - BASE;
                    if (off[15:0] == 16'h0000)
                        msip = 32'(apply_strb({32'h0, msip}, wdata_cap, wstrb_cap));
                    else if (off[15:0] == 16'h4000)
                        mtimecmp = apply_strb(mtimecmp, wdata_cap, wstrb_cap);
                end else b_wait++;
            end
            b_armed = bvalid && bready;
            // R channel
            if (rvalid && r_armed) begin rvalid = 0; r_cnt++; end
            if (r_pend && !rvalid) begin
                if (r_wait == r_delay) begin
                    rvalid = 1; rid = rid_cfg; rresp = rresp_cfg; rlast = rlast_cfg;
                    rdata = model_read(ar_addr_cap); r_pend = 0;
                end else r_wait++;
            end
            r_armed = rvalid && rready;
            // AW channel
            if (awvalid) begin
                any_valid = 1; aw_hi++;
                if (aw_prev_v && awaddr !== aw_prev_a) stab_err++;
                if (aw_wait == aw_delay) begin
                    awready = 1; aw_cnt++; aw_addr_cap = awaddr; aw_hi_last = aw_hi;
                    aw_hi = 0; aw_wait = 0; aw_got = 1;
                    check("awlen", 64'(awlen), 64'd0);
                    check("awsize", 64'(awsize), 64'd3);
                    check("awburst", 64'(awburst), 64'd1);
                    check("awid", 64'(awid), 64'd0);
                end else begin awready = 0; aw_wait++; end
            end else awready = 0;
            aw_prev_v = awvalid && !awready; aw_prev_a = awaddr;
            // W channel
            if (wvalid) begin
                any_valid = 1; w_hi++;
                if (w_prev_v && wdata !== w_prev_d) stab_err++;
                if (w_wait == w_delay) begin
                    wready = 1; w_cnt++; wdata_cap = wdata; wstrb_cap = wstrb;
                    w_hi_last = w_hi; w_hi = 0; w_wait = 0; w_got = 1;
                    check("wlast", 64'(wlast), 64'd1);
                end else begin wready = 0; w_wait++; end
            end else wready = 0;
            w_prev_v = wvalid && !wready; w_prev_d = wdata;
            if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end
            // AR channel
            if (arvalid) begin
                any_valid = 1; ar_hi++;
                if (ar_prev_v && araddr !== ar_prev_a) stab_err++;
                if (ar_wait == ar_delay) begin
                    arready = 1; ar_cnt++; ar_addr_cap = araddr; ar_hi_last = ar_hi;
                    ar_hi = 0; ar_wait = 0; r_pend = 1; r_wait = 0;
                    check("arlen", 64'(arlen), 64'd0);
                    check("arsize", 64'(arsize), 64'd3);
                    check("arid", 64'(arid), 64'd0);
                end else begin arready = 0; ar_wait++; end
            end else arready = 0;
            ar_prev_v = arvalid && !arready; ar_prev_a = araddr;
        end
    end

    // Issue one command; lat counts cycles from acceptance to rsp_valid.
    // With take set, the response is held one extra cycle, then accepted.
    task automatic run_cmd(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [7:0] ws, input bit take,
                           output logic [63:0] rd, output logic er, output int lat);
        int n = 0;
        @(negedge aclk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
        if (!cmd_ready) check("cmd_ready_timeout", 64'd0, 64'd1);
        @(negedge aclk);
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge aclk); lat++; end
        if (!rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
        rd = rsp_rdata; er = rsp_err;
        if (take) begin
            @(negedge aclk);
            check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            check("rsp_hold_data", rsp_rdata, rd);
            rsp_ready = 1;
            @(negedge aclk);
            rsp_ready = 0;
            check("back_to_idle", 64'({rsp_valid, cmd_ready}), 64'b01);
        end
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat, aw0, w0, b0, ar0;

        repeat (3) @(negedge aclk);
        areset = 0;
        // Reset values
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_valids", 64'({rsp_valid, awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        check("rst_rsp", {rsp_rdata[62:0], rsp_err}, 64'd0);

        // Zero-wait write of 1 to msip
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        run_cmd(1, BASE, 64'h1, 8'hFF, 1, rd, er, lat);
        check("wr_lat", 64'(lat), 64'd3);
        check("wr_err", 64'(er), 64'd0);
        check("wr_rdata", rd, 64'd0);
        check("wr_aw_cnt", 64'(aw_cnt - aw0), 64'd1);
        check("wr_w_cnt", 64'(w_cnt - w0), 64'd1);
        check("wr_b_cnt", 64'(b_cnt - b0), 64'd1);
        check("wr_awaddr", aw_addr_cap, BASE);
        check("wr_wdata", wdata_cap, 64'h1);
        check("wr_wstrb", 64'(wstrb_cap), 64'hFF);
        check("ipi", 64'(ipi), 64'd1);

        // Zero-wait read latency
        run_cmd(0, BASE, 64'h0, 8'h00, 1, rd, er, lat);
        check("rd0_lat", 64'(lat), 64'd3);
        check("rd0_msip", rd, 64'h1);

        // Delayed read of mtime
        ar_delay = 4; r_delay = 2;
        run_cmd(0, BASE + 64'hBFF8, 64'h0, 8'h00, 1, rd, er, lat);
        ar_delay = 0; r_delay = 0;
        check("rd_ar_hi", 64'(ar_hi_last), 64'd5);
        check("rd_araddr", ar_addr_cap, BASE + 64'hBFF8);
        check("rd_lat", 64'(lat), 64'd9);
        check("rd_mtime", rd, MTIME_VAL);
        check("rd_err", 64'(er), 64'd0);

        // W accepted before AW, then the reverse
        b0 = b_cnt; aw_delay = 3; w_delay = 0;
        run_cmd(1, BASE + 64'h4000, 64'h1111_2222_3333_4444, 8'hFF, 1, rd, er, lat);
        check("wfirst_aw_hi", 64'(aw_hi_last), 64'd4);
        check("wfirst_w_hi", 64'(w_hi_last), 64'd1);
        check("wfirst_lat", 64'(lat), 64'd6);
        check("wfirst_err", 64'(er), 64'd0);
        aw_delay = 0; w_delay = 3;
        run_cmd(1, BASE + 64'h4000, 64'h5555_6666_7777_8888, 8'h0F, 1, rd, er, lat);
        check("awfirst_aw_hi", 64'(aw_hi_last), 64'd1);
        check("awfirst_w_hi", 64'(w_hi_last), 64'd4);
        check("awfirst_lat", 64'(lat), 64'd6);
        check("awfirst_err", 64'(er), 64'd0);
        check("order_b_cnt", 64'(b_cnt - b0), 64'd2);
        w_delay = 0;
        run_cmd(0, BASE + 64'h4000, 64'h0, 8'h00, 1, rd, er, lat);
        check("mtimecmp_rb", rd, 64'h1111_2222_7777_8888);

        // Error responses
        rresp_cfg = 2'b10;
        run_cmd(0, BASE, 64'h0, 8'h00, 1, rd, er, lat);
        rresp_cfg = 2'b00;
        check("slverr_err", 64'(er), 64'd1);
        bid_cfg = 10'd1;
        run_cmd(1, BASE, 64'h0, 8'hFF, 1, rd, er, lat);
        bid_cfg = 10'd0;
        check("bid_err", 64'(er), 64'd1);
        rlast_cfg = 1'b0;
        run_cmd(0, BASE, 64'h0, 8'h00, 1, rd, er, lat);
        rlast_cfg = 1'b1;
        check("rlast_err", 64'(er), 64'd1);
        run_cmd(0, BASE, 64'h0, 8'h00, 1, rd, er, lat);
        check("after_err_err", 64'(er), 64'd0);
        check("after_err_msip", rd, 64'h0);

        // Misaligned: answered locally with no bus traffic
        any_valid = 0; aw0 = aw_cnt; ar0 = ar_cnt;
        run_cmd(1, BASE + 64'h4004, 64'hDEAD, 8'hFF, 1, rd, er, lat);
        check("mis_lat", 64'(lat), 64'd1);
        check("mis_err", 64'(er), 64'd1);
        check("mis_no_valid", 64'(any_valid), 64'd0);
        check("mis_cnt", 64'((aw_cnt - aw0) + (ar_cnt - ar0)), 64'd0);

        // Reset while a response is pending
        run_cmd(0, BASE + 64'hBFF8, 64'h0, 8'h00, 0, rd, er, lat);
        check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        @(negedge aclk);
        areset = 1;
        @(negedge aclk);
        areset = 0;
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_rst_axi", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        run_cmd(0, BASE + 64'hBFF8, 64'h0, 8'h00, 1, rd, er, lat);
        check("post_rst_lat", 64'(lat), 64'd3);
        check("post_rst_rd", rd, MTIME_VAL);
        check("post_rst_err", 64'(er), 64'd0);

        check("payload_stable", 64'(stab_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
